// File: rtl/kp_pkg.sv
// Shared types, key codes and helper functions for the keypad entry controller.
package kp_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    ACCEPT,
    RELEASE
  } kp_state_t;

  localparam int KEY_ENTER  = 10;
  localparam int KEY_CLEAR  = 11;
  localparam int NUM_DIGITS = 4;
  localparam int MAX_VALUE  = 9999;
  localparam int NUM_KEYS   = 12;
  localparam int VALUE_W    = $clog2(MAX_VALUE + 1);

  function automatic logic [3:0] onehotToCode(input logic [NUM_KEYS-1:0] oh);
    logic [3:0] code;
    code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (oh[i]) code = 4'(i);
    end
    return code;
  endfunction

  // Horner evaluation: ((d3*10 + d2)*10 + d1)*10 + d0
  function automatic logic [VALUE_W-1:0] bcdToBin(input logic [4*NUM_DIGITS-1:0] bcd);
    logic [VALUE_W-1:0] acc;
    bcd_digit_t         d;
    acc = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      d   = bcd[4*i +: 4];
      acc = acc * VALUE_W'(10) + VALUE_W'(d);
    end
    return acc;
  endfunction

endpackage

// File: rtl/kp_debounce.sv
// Synchronises the raw key lines, rejects multi-key patterns and debounces press and
// release, giving one press strobe per key press. KEYPAD_TIMEOUT_EN exposes an idle flag.
module kp_debounce
  import kp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] i_keys,
`ifdef KEYPAD_TIMEOUT_EN
  output logic                o_idle,
`endif
  output logic                o_press,
  output logic [3:0]          o_code
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_cand;
  logic [NUM_KEYS-1:0] w_candNext;
  logic [NUM_KEYS-1:0] w_pat;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cntNext;
  kp_state_t           r_state;
  kp_state_t           w_stateNext;
  logic                w_oneHot;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_keys;
      r_sync2 <= r_sync1;
    end
  end

  // Chords are treated as "nothing pressed" so they can never start a debounce
  assign w_oneHot = (r_sync2 != '0) && ((r_sync2 & (r_sync2 - NUM_KEYS'(1))) == '0);
  assign w_pat    = w_oneHot ? r_sync2 : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_cand  <= w_candNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_candNext  = r_cand;
    case (r_state)
      IDLE: begin
        if (w_oneHot) begin
          w_candNext  = w_pat;
          w_cntNext   = '0;
          w_stateNext = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (w_pat != r_cand)     w_stateNext = IDLE;
        else if (r_cnt == CNT_LAST) w_stateNext = ACCEPT;
        else                     w_cntNext   = r_cnt + CW'(1);
      end
      ACCEPT: begin
        w_cntNext   = '0;
        w_stateNext = RELEASE;
      end
      RELEASE: begin
        // Any activity, even a chord, restarts the release window so holds never repeat
        if (r_sync2 != '0)          w_cntNext   = '0;
        else if (r_cnt == CNT_LAST) w_stateNext = IDLE;
        else                        w_cntNext   = r_cnt + CW'(1);
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign o_press = (r_state == ACCEPT);
  assign o_code  = onehotToCode(r_cand);
`ifdef KEYPAD_TIMEOUT_EN
  assign o_idle  = (r_state == IDLE);
`endif

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: 4-digit BCD entry buffer fed by debounced key presses and
// committed to binary on ENTER. Define KEYPAD_TIMEOUT_EN to auto-clear an idle entry.
module keypad_entry_ctrl
  import kp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
`ifdef KEYPAD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 1000
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              key_i,
  input  logic                    enter_i,
  input  logic                    clear_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [2:0]              ndigits_o,
  output logic                    entry_full_o,
  output logic [VALUE_W-1:0]      value_o,
  output logic                    value_valid_o,
  output logic                    timeout_o
);

  logic                    w_press;
  logic [3:0]              w_code;
  logic                    w_full;
  logic                    w_timeoutHit;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [2:0]              r_ndigits;
  logic [VALUE_W-1:0]      r_value;
  logic                    r_valueValid;
`ifdef KEYPAD_TIMEOUT_EN
  logic                    w_idle;
`endif

  kp_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .i_keys ({clear_i, enter_i, key_i}),
`ifdef KEYPAD_TIMEOUT_EN
    .o_idle (w_idle),
`endif
    .o_press(w_press),
    .o_code (w_code)
  );

  assign w_full = (r_ndigits == 3'(NUM_DIGITS));

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_idleCnt;
  logic          r_timeout;

  assign w_timeoutHit = w_idle && (r_ndigits != '0) && (r_idleCnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idleCnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeoutHit;
      if (w_press || w_timeoutHit)         r_idleCnt <= '0;
      else if (w_idle && r_ndigits != '0) r_idleCnt <= r_idleCnt + TW'(1);
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_timeoutHit = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digits     <= '0;
      r_ndigits    <= '0;
      r_value      <= '0;
      r_valueValid <= 1'b0;
    end else begin
      r_valueValid <= 1'b0;
      if (w_press) begin
        if (w_code < 4'(KEY_ENTER)) begin
          if (!w_full) begin
            r_digits  <= {r_digits[4*NUM_DIGITS-5:0], w_code};
            r_ndigits <= r_ndigits + 3'd1;
          end
        end else if (w_code == 4'(KEY_ENTER)) begin
          if (r_ndigits != '0) begin
            r_value      <= bcdToBin(r_digits);
            r_valueValid <= 1'b1;
            r_digits     <= '0;
            r_ndigits    <= '0;
          end
        end else begin
          r_digits  <= '0;
          r_ndigits <= '0;
        end
      end else if (w_timeoutHit) begin
        r_digits  <= '0;
        r_ndigits <= '0;
      end
    end
  end

  assign digits_o      = r_digits;
  assign ndigits_o     = r_ndigits;
  assign entry_full_o  = w_full;
  assign value_o       = r_value;
  assign value_valid_o = r_valueValid;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus random key sequences checked
// against a digit-list model; commits are scoreboarded. Honours KEYPAD_TIMEOUT_EN.
module tb_keypad_entry_ctrl;

  localparam int DEB    = 4;
  localparam int SETTLE = 2 * DEB + 6;
`ifdef KEYPAD_TIMEOUT_EN
  localparam int TMO           = 50;
  localparam bit TIMEOUT_BUILD = 1'b1;
`else
  localparam bit TIMEOUT_BUILD = 1'b0;
`endif

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic [9:0]  key_i   = '0;
  logic        enter_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [15:0] digits_o;
  logic [2:0]  ndigits_o;
  logic        entry_full_o;
  logic [13:0] value_o;
  logic        value_valid_o;
  logic        timeout_o;

  int checks      = 0;
  int failures    = 0;
  int timeoutSeen = 0;
  int monExp;
  int mDigits[$];
  int mValue = 0;
  int expValQ[$];

  always #5 clk = ~clk;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES(DEB)
`ifdef KEYPAD_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_i        (key_i),
    .enter_i      (enter_i),
    .clear_i      (clear_i),
    .digits_o     (digits_o),
    .ndigits_o    (ndigits_o),
    .entry_full_o (entry_full_o),
    .value_o      (value_o),
    .value_valid_o(value_valid_o),
    .timeout_o    (timeout_o)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: the entry is a list of decimal digits, oldest first
  function automatic int modelPacked();
    int p = 0;
    foreach (mDigits[i]) p = p * 16 + mDigits[i];
    return p;
  endfunction

  function automatic int modelDecimal();
    int v = 0;
    foreach (mDigits[i]) v = v * 10 + mDigits[i];
    return v;
  endfunction

  task automatic modelPress(input int code);
    if (code < 10) begin
      if (mDigits.size() < 4) mDigits.push_back(code);
    end else if (code == 10) begin
      if (mDigits.size() > 0) begin
        mValue = modelDecimal();
        expValQ.push_back(mValue);
        mDigits.delete();
      end
    end else begin
      mDigits.delete();
    end
  endtask

  task automatic driveCode(input int code, input logic v);
    if (code < 10)       key_i[code] = v;
    else if (code == 10) enter_i = v;
    else                 clear_i = v;
  endtask

  // A raw hold of DEB+1 cycles or more is a press; DEB-1 or fewer is a bounce
  task automatic applyStimulus(input int code, input int hold);
    if (hold >= DEB + 1) modelPress(code);
    @(negedge clk);
    driveCode(code, 1'b1);
    repeat (hold) @(negedge clk);
    driveCode(code, 1'b0);
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic applyChord(input logic [11:0] pat, input int hold);
    @(negedge clk);
    {clear_i, enter_i, key_i} = pat;
    repeat (hold) @(negedge clk);
    {clear_i, enter_i, key_i} = '0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, " digits_o"}, int'(digits_o), modelPacked());
    checkOutput({tag, " ndigits_o"}, int'(ndigits_o), mDigits.size());
    checkOutput({tag, " entry_full_o"}, int'(entry_full_o), int'(mDigits.size() == 4));
    checkOutput({tag, " value_o"}, int'(value_o), mValue);
  endtask

  // Commit monitor: every value_valid_o pulse must match the oldest expected commit
  always @(negedge clk) begin
    if (reset) begin
      if (value_valid_o) begin
        if (expValQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected commit: got value_o=%0d, expected no pulse", value_o);
        end else begin
          monExp = expValQ.pop_front();
          checkOutput("commit value_o", int'(value_o), monExp);
        end
      end
      if (timeout_o) timeoutSeen++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seq[4];
    int tsBefore;
    int r;
    int a;
    int b;

    repeat (3) @(negedge clk);
    checkOutput("reset digits_o", int'(digits_o), 0);
    checkOutput("reset ndigits_o", int'(ndigits_o), 0);
    checkOutput("reset entry_full_o", int'(entry_full_o), 0);
    checkOutput("reset value_o", int'(value_o), 0);
    checkOutput("reset value_valid_o", int'(value_valid_o), 0);
    checkOutput("reset timeout_o", int'(timeout_o), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(3, 10);
    checkOutput("hold3 digits_o", int'(digits_o), 16'h0003);
    checkOutput("hold3 ndigits_o", int'(ndigits_o), 1);
    applyStimulus(11, 6);
    checkState("clear");

    seq = '{1, 2, 3, 4};
    foreach (seq[i]) applyStimulus(seq[i], 6);
    checkOutput("1234 digits_o", int'(digits_o), 16'h1234);
    checkState("1234");
    applyStimulus(10, 6);
    checkState("enter 1234");

    applyStimulus(5, 2);
    checkState("short press");
    applyChord(12'h084, 20);
    checkState("chord 2+7");
    applyStimulus(10, 6);
    checkState("enter empty");

    seq = '{9, 8, 7, 6};
    foreach (seq[i]) applyStimulus(seq[i], 7);
    applyStimulus(9, 6);
    checkState("full ignore");
    applyStimulus(11, 6);
    checkState("clear holds value");

    // Reset while key 6 is mid-debounce, key stays held through and after reset
    @(negedge clk);
    key_i[6] = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    mDigits.delete();
    mValue = 0;
    checkState("async reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mDigits.push_back(6);
    repeat (15) @(negedge clk);
    key_i[6] = 1'b0;
    repeat (SETTLE) @(negedge clk);
    checkOutput("post-reset digits_o", int'(digits_o), 16'h0006);
    checkState("post-reset");

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        applyStimulus($urandom_range(0, 9), $urandom_range(DEB + 1, 12));
      end else if (r < 72) begin
        applyStimulus(10, $urandom_range(DEB + 1, 10));
      end else if (r < 82) begin
        applyStimulus(11, $urandom_range(DEB + 1, 10));
      end else if (!TIMEOUT_BUILD || mDigits.size() == 0) begin
        if (r < 91) begin
          applyStimulus($urandom_range(0, 11), $urandom_range(1, DEB - 1));
        end else begin
          a = $urandom_range(0, 11);
          b = (a + $urandom_range(1, 11)) % 12;
          applyChord(12'(1 << a) | 12'(1 << b), $urandom_range(2, 20));
        end
      end else begin
        applyStimulus($urandom_range(0, 9), DEB + 2);
      end
      checkState("random");
    end

`ifdef KEYPAD_TIMEOUT_EN
    applyStimulus(11, 6);
    applyStimulus(7, 6);
    checkOutput("timeout pre digits_o", int'(digits_o), 16'h0007);
    tsBefore = timeoutSeen;
    repeat (TMO + 30) @(negedge clk);
    mDigits.delete();
    checkOutput("timeout pulses", timeoutSeen - tsBefore, 1);
    checkState("after timeout");
    applyStimulus(10, 6);
    checkState("enter after timeout");
`else
    tsBefore = 0;
    checkOutput("timeout_o pulses", timeoutSeen - tsBefore, 0);
`endif

    repeat (4) @(negedge clk);
    checkOutput("pending commits", expValQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
